// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller and gradient datapath.
package sobel_pkg;
   localparam int DSIZE   = 8;
   localparam int GRDSIZE = 11;
   localparam int ANGSIZE = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } sobel_state_t;

   // Flat window slots: top-left is the most significant pixel, bottom-right the least.
   localparam int WIN_SLOTS = 9;
   localparam int WIN_TL    = 8;
   localparam int WIN_BR    = 0;

   function automatic int win_slot(input int row, input int col);
      return WIN_TL - (row * 3 + col);
   endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// Two WIDTH-deep line buffers; lb1 takes the old lb0 contents of the column being written.
module sobel_line_buf #(
   parameter int WIDTH = 640,
   parameter int DSIZE = 8,
   localparam int AW   = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [DSIZE-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [DSIZE-1:0] o_lb0,
   output logic [DSIZE-1:0] o_lb1
);
   logic [DSIZE-1:0] lb0_mem [0:WIDTH-1];
   logic [DSIZE-1:0] lb1_mem [0:WIDTH-1];
   logic [DSIZE-1:0] lb0_rd_reg;
   logic [DSIZE-1:0] lb1_rd_reg;

   // Read is read-first; the caller addresses it with the column that will be written next.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         lb0_mem[i_wr_addr] <= i_wr_data;
         lb1_mem[i_wr_addr] <= lb0_rd_reg;
      end
      lb0_rd_reg <= lb0_mem[i_rd_addr];
      lb1_rd_reg <= lb1_mem[i_rd_addr];
   end

   assign o_lb0 = lb0_rd_reg;
   assign o_lb1 = lb1_rd_reg;
endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-scan 3x3 window sequencer feeding the Sobel datapath.
// Optional SOBEL_CTRL_STALL_EN adds an i_stall backpressure input.
module sobel_window_ctrl #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DSIZE  = sobel_pkg::DSIZE,
   localparam int XW    = $clog2(WIDTH),
   localparam int YW    = $clog2(HEIGHT)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_valid,
   input  logic [DSIZE-1:0]   i_pixel,
`ifdef SOBEL_CTRL_STALL_EN
   input  logic               i_stall,
`endif
   output logic               o_ready,
   output logic [9*DSIZE-1:0] o_window,
   output logic               o_win_valid,
   output logic               o_grad_valid,
   output logic [XW-1:0]      o_x,
   output logic [YW-1:0]      o_y,
   output logic               o_busy,
   output logic               o_frame_done
);
   import sobel_pkg::*;

   sobel_state_t     state_reg;
   logic [XW-1:0]    col_reg, col_next;
   logic [YW-1:0]    row_reg;
   logic [1:0]       drain_reg;
   logic [DSIZE-1:0] win_reg     [0:2][0:2];
   logic [DSIZE-1:0] win_shift   [0:2][0:2];
   logic [DSIZE-1:0] win_out_reg [0:2][0:2];
   logic [DSIZE-1:0] new_col     [0:2];
   logic [DSIZE-1:0] lb0_rd, lb1_rd;
   logic             accept, issue, col_last, row_last;
   logic [XW-1:0]    x1_reg, x_reg;
   logic [YW-1:0]    y1_reg, y_reg;
   logic             last1_reg, win_valid_reg, grad_valid_reg, frame_done_reg;

`ifdef SOBEL_CTRL_STALL_EN
   assign o_ready = ((state_reg == PRIME) || (state_reg == STREAM)) && !i_stall;
`else
   assign o_ready = (state_reg == PRIME) || (state_reg == STREAM);
`endif

   assign accept   = i_valid && o_ready;
   assign col_last = (col_reg == XW'(WIDTH - 1));
   assign row_last = (row_reg == YW'(HEIGHT - 1));
   assign issue    = accept && (state_reg == STREAM) && (col_reg >= XW'(2));

   always_comb begin
      col_next = col_reg;
      if (i_rst || ((state_reg == IDLE) && i_start))
         col_next = '0;
      else if (accept)
         col_next = col_last ? '0 : col_reg + 1'b1;
   end

   sobel_line_buf #(.WIDTH(WIDTH), .DSIZE(DSIZE)) u_line_buf (
      .i_clk     (i_clk),
      .i_we      (accept && !i_rst),
      .i_wr_addr (col_reg),
      .i_wr_data (i_pixel),
      .i_rd_addr (col_next),
      .o_lb0     (lb0_rd),
      .o_lb1     (lb1_rd)
   );

   // Incoming column: oldest line on top, live pixel at the bottom.
   assign new_col[0] = lb1_rd;
   assign new_col[1] = lb0_rd;
   assign new_col[2] = i_pixel;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_shift
         assign win_shift[gi][0] = win_reg[gi][1];
         assign win_shift[gi][1] = win_reg[gi][2];
         assign win_shift[gi][2] = new_col[gi];
         for (gj = 0; gj < 3; gj++) begin : g_flat
            assign o_window[win_slot(gi, gj)*DSIZE +: DSIZE] = win_out_reg[gi][gj];
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= IDLE;
         col_reg        <= '0;
         row_reg        <= '0;
         drain_reg      <= '0;
         x1_reg         <= '0;
         y1_reg         <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         last1_reg      <= 1'b0;
         win_valid_reg  <= 1'b0;
         grad_valid_reg <= 1'b0;
         frame_done_reg <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               win_reg[r][c]     <= '0;
               win_out_reg[r][c] <= '0;
            end
      end else begin
         col_reg        <= col_next;
         win_valid_reg  <= issue;
         grad_valid_reg <= win_valid_reg;
         frame_done_reg <= win_valid_reg && last1_reg;
         x_reg          <= x1_reg;
         y_reg          <= y1_reg;
         if (accept) begin
            win_reg <= win_shift;
            if (col_last)
               row_reg <= row_last ? '0 : row_reg + 1'b1;
         end
         if (issue) begin
            win_out_reg <= win_shift;
            x1_reg      <= col_reg - 1'b1;
            y1_reg      <= row_reg - 1'b1;
            last1_reg   <= col_last && row_last;
         end
         case (state_reg)
            IDLE:   if (i_start) begin
                       state_reg <= PRIME;
                       row_reg   <= '0;
                    end
            PRIME:  if (accept && col_last && (row_reg == YW'(1)))
                       state_reg <= STREAM;
            STREAM: if (accept && col_last && row_last) begin
                       state_reg <= DONE;
                       drain_reg <= '0;
                    end
            DONE:   begin
                       drain_reg <= drain_reg + 1'b1;
                       if (drain_reg == 2'd1)
                          state_reg <= IDLE;
                    end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign o_win_valid  = win_valid_reg;
   assign o_grad_valid = grad_valid_reg;
   assign o_frame_done = frame_done_reg;
   assign o_x          = x_reg;
   assign o_y          = y_reg;
   assign o_busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_sobel_window_ctrl;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DS = 8;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          i_rst = 1'b1, i_start = 1'b0, i_valid = 1'b0;
   logic [DS-1:0] i_pixel = '0;
`ifdef SOBEL_CTRL_STALL_EN
   logic          i_stall = 1'b0;
`endif
   logic          o_ready, o_win_valid, o_grad_valid, o_busy, o_frame_done;
   logic [9*DS-1:0] o_window;
   logic [XW-1:0] o_x;
   logic [YW-1:0] o_y;

   sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .DSIZE(DS)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_valid      (i_valid),
      .i_pixel      (i_pixel),
`ifdef SOBEL_CTRL_STALL_EN
      .i_stall      (i_stall),
`endif
      .o_ready      (o_ready),
      .o_window     (o_window),
      .o_win_valid  (o_win_valid),
      .o_grad_valid (o_grad_valid),
      .o_x          (o_x),
      .o_y          (o_y),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: frame phase, accepted-pixel history, expected outputs for the next cycle.
   bit          model_on = 0;
   int          phase = 0, drain = 0, idx = 0;
   logic [7:0]  acc_pix [0:W*H-1];
   logic        e_wv = 0, e_gv = 0, e_fd = 0, p_last = 0;
   logic [71:0] e_win = '0;
   int          e_x = 0, e_y = 0, p_x = 0, p_y = 0;
   bit          ramp_frame = 0;
   int          win_cnt = 0, grad_cnt = 0;

   always @(negedge clk) begin
      bit          e_ready;
      bit          acc;
      logic [71:0] w;
      int          x, y;
      e_ready = (phase == 1);
`ifdef SOBEL_CTRL_STALL_EN
      e_ready = e_ready && !i_stall;
`endif
      if (model_on) begin
         chk("ready", o_ready, e_ready);
         chk("busy", o_busy, phase != 0);
         chk("win_valid", o_win_valid, e_wv);
         chk("grad_valid", o_grad_valid, e_gv);
         chk("frame_done", o_frame_done, e_fd);
         chk("window", o_window, e_win);
         if (e_gv) begin
            chk("x", o_x, e_x);
            chk("y", o_y, e_y);
         end
         if (ramp_frame) begin
            if (o_win_valid && win_cnt == 0)
               chk("first_window_lit", o_window, 72'h000102_08090a_101112);
            if (o_grad_valid && grad_cnt == 0) begin
               chk("first_x_lit", o_x, 1);
               chk("first_y_lit", o_y, 1);
            end
            if (o_frame_done) begin
               chk("last_x_lit", o_x, 6);
               chk("last_y_lit", o_y, 4);
               chk("win_count_lit", win_cnt, 24);
            end
         end
         if (o_win_valid) win_cnt++;
         if (o_grad_valid) grad_cnt++;
      end

      if (i_rst) begin
         model_on = 1; phase = 0; drain = 0; idx = 0;
         e_wv = 0; e_gv = 0; e_fd = 0; e_win = '0;
         e_x = 0; e_y = 0; p_x = 0; p_y = 0; p_last = 0;
      end else if (model_on) begin
         acc  = i_valid && e_ready;
         e_gv = e_wv;
         e_fd = e_wv && p_last;
         e_x  = p_x;
         e_y  = p_y;
         e_wv = 0;
         case (phase)
            0: if (i_start) begin
                  phase = 1; idx = 0; win_cnt = 0; grad_cnt = 0;
               end
            1: if (acc) begin
                  acc_pix[idx] = i_pixel;
                  x = idx % W;
                  y = idx / W;
                  if (x >= 2 && y >= 2) begin
                     w = '0;
                     for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                           w[(8 - (r*3 + c))*8 +: 8] = acc_pix[(y - 2 + r)*W + (x - 2 + c)];
                     e_wv = 1; e_win = w;
                     p_x = x - 1; p_y = y - 1; p_last = (idx == W*H - 1);
                  end
                  idx++;
                  if (idx == W*H) begin
                     phase = 2; drain = 0;
                  end
               end
            default: begin
                  drain++;
                  if (drain == 2) phase = 0;
               end
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix_of(input int mode, input int n);
      int x, y;
      x = n % W;
      y = n / W;
      case (mode)
         0: return 8'(W*y + x);
         2: return 8'd100;
         3: return (x < 4) ? 8'd0 : 8'd255;
         default: return 8'($urandom);
      endcase
   endfunction

   // vmode: 0 continuous, 1 alternate cycles, 2 random; abort_at < 0 runs the whole frame.
   task automatic run_frame(input int mode, input int vmode, input int abort_at);
      int dcount = 0, guard = 0;
      bit acc_d, tog = 0;
`ifdef SOBEL_CTRL_STALL_EN
      int hold = 0;
      bit held = 0;
`endif
      i_start = 1;
      step();
      i_start = 0;
      while (dcount < W*H && guard < 4000) begin
         case (vmode)
            0: i_valid = 1;
            1: begin i_valid = tog; tog = !tog; end
            default: i_valid = ($urandom_range(0, 99) < 70);
         endcase
         i_pixel = pix_of(mode, dcount);
         i_start = ($urandom_range(0, 15) == 0);
`ifdef SOBEL_CTRL_STALL_EN
         if (!held && dcount == 20) begin hold = 5; held = 1; end
         i_stall = (hold > 0) || (vmode == 2 && $urandom_range(0, 7) == 0);
         if (hold > 0) hold--;
`endif
         @(negedge clk);
         acc_d = i_valid && o_ready;
         step();
         if (acc_d) dcount++;
         guard++;
         if (dcount == abort_at) begin
            i_valid = 0; i_start = 0; i_rst = 1;
`ifdef SOBEL_CTRL_STALL_EN
            i_stall = 0;
`endif
            step();
            i_rst = 0;
            repeat (3) step();
            return;
         end
      end
      i_valid = 0;
      i_start = 0;
`ifdef SOBEL_CTRL_STALL_EN
      i_stall = 0;
`endif
      if (guard >= 4000) chk("frame_timeout", 1, 0);
      guard = 0;
      while (phase != 0 && guard < 20) begin
         step();
         guard++;
      end
      if (phase != 0) chk("drain_timeout", phase, 0);
      repeat (2) step();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      i_rst = 0;
      @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_window", o_window, 0);
      chk("rst_x", o_x, 0);
      chk("rst_y", o_y, 0);
      chk("rst_frame_done", o_frame_done, 0);
      step();
      // Pixels offered in IDLE must be dropped.
      for (int k = 0; k < 4; k++) begin
         i_valid = 1;
         i_pixel = 8'($urandom);
         step();
      end
      i_valid = 0;
      // Start coincident with reset: reset wins.
      i_start = 1; i_rst = 1;
      step();
      i_start = 0; i_rst = 0;
      repeat (2) step();

      ramp_frame = 1;
      run_frame(0, 0, -1);
      run_frame(0, 1, -1);
      ramp_frame = 0;
      run_frame(1, 2, 30);
      ramp_frame = 1;
      run_frame(0, 0, -1);
      ramp_frame = 0;
      run_frame(2, 2, -1);
      run_frame(3, 0, -1);
      run_frame(1, 2, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Raster-scan controller that sequences the SOBEL gradient datapath. It accepts one 8-bit luma pixel per handshake, keeps the two previous lines in line buffers, and assembles the 3x3 neighbourhood in the order SOBEL expects. It issues one window per interior pixel and aligns a valid flag and centre coordinates with SOBEL's registered gradient/angle output. It sits between the camera grey-scale stage and the SOBEL instance, which it does not contain.

## Interface

Parameters:
- WIDTH, 640: pixels per line, at least 3
- HEIGHT, 480: lines per frame, at least 3
- DSIZE, 8: pixel width

Ports:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_valid  in  1  i_pixel valid
- i_pixel  in  DSIZE  raster-order pixel
- i_stall  in  1  downstream backpressure; present only with SOBEL_CTRL_STALL_EN
- o_ready  out  1  pixel accepted when i_valid && o_ready
- o_window  out  9*DSIZE  3x3 window to SOBEL i_pixel; [71:64]=top-left, row-major, [7:0]=bottom-right
- o_win_valid  out  1  o_window holds a new window this cycle (one-cycle pulse)
- o_grad_valid  out  1  SOBEL o_grad/o_angle valid this cycle
- o_x  out  $clog2(WIDTH)  centre column of the window behind o_grad_valid
- o_y  out  $clog2(HEIGHT)  centre row of the window behind o_grad_valid
- o_busy  out  1  state != IDLE
- o_frame_done  out  1  one-cycle pulse on the last o_grad_valid of the frame

## Operation

- States:
  - IDLE: o_ready=0. i_start moves to PRIME, clearing col/row counters.
  - PRIME: rows 0–1. Pixels are accepted and written to the line buffers. No windows are issued.
  - STREAM: rows 2..HEIGHT-1. A window is issued for every accepted pixel with col>=2.
  - DONE: entered after the pixel at (WIDTH-1, HEIGHT-1) is accepted. o_ready=0. Waits 2 cycles for the pipeline to drain, then returns to IDLE.
- On accepting a pixel at column c:
  - New column = {lb1[c], lb0[c], i_pixel}. Window registers shift left by one column and load the new column on the right.
  - Then lb1[c] <= lb0[c] and lb0[c] <= i_pixel.
- Counters:
  - col wraps WIDTH-1 -> 0 and increments row.
  - PRIME -> STREAM when row becomes 2.
- Centre coordinate = (col-1, row-1) of the triggering pixel. It is carried through a 2-stage pipeline to o_x/o_y.
- Window count per frame is exactly (WIDTH-2)*(HEIGHT-2). Border pixels produce no output.
- o_window holds its value between pulses.
- The line buffers are not cleared between frames. The PRIME rows overwrite them before any use.
- Boundary conditions:
  - i_valid while o_ready=0: pixel is dropped and nothing changes.
  - i_start outside IDLE: ignored.
  - i_start and i_rst in the same cycle: reset wins.
  - i_rst mid-frame: next cycle is IDLE with all outputs at reset values. The partial frame is discarded and no o_frame_done pulse is produced.

## Timing

- Reset values:
  - o_ready=0, o_window=0, o_win_valid=0, o_grad_valid=0, o_x=0, o_y=0, o_busy=0, o_frame_done=0.
  - State is IDLE.
  - Counters and the window are 0.
- o_ready is 1 in PRIME/STREAM (and !i_stall with the macro), combinational from state.
- Latency:
  - Pixel accepted at cycle t -> o_window/o_win_valid at t+1.
  - SOBEL registers at t+2 -> o_grad_valid, o_x, o_y at t+2.
- o_frame_done is coincident with the final o_grad_valid, 2 cycles after the last pixel is accepted. DONE -> IDLE on the following edge.
- Back-to-back acceptance gives one window per cycle.

## Configuration

- SOBEL_CTRL_STALL_EN defined:
  - i_stall port exists and o_ready = state accepts && !i_stall.
  - Stall only blocks acceptance. In-flight windows still complete and o_grad_valid is not held.
- Undefined: no i_stall port; o_ready depends only on state.

## Structure

- Shared package sobel_pkg holds:
  - DSIZE, GRDSIZE, ANGSIZE constants.
  - The state enum typedef (IDLE, PRIME, STREAM, DONE).
  - The window index constants.
- Sub-module sobel_line_buf: one instance holding both WIDTH x DSIZE lines.
  - Read and write at the same column in the same cycle.
  - Read returns the old data.

## Test plan

- Reset mid-STREAM (WIDTH=8, HEIGHT=6) -> next cycle all outputs 0 and o_busy=0. No o_frame_done pulse. A fresh i_start then produces a correct full frame.
- WIDTH=8, HEIGHT=6, pixel(x,y)=8y+x, continuous i_valid -> exactly 24 o_win_valid pulses.
  - First pulse: o_window = {0,1,2,8,9,10,16,17,18}.
  - First o_grad_valid has o_x=1, o_y=1. The last is o_x=6, o_y=4, coincident with o_frame_done.
- Same frame with i_valid toggling every other cycle -> identical window sequence. Each o_grad_valid arrives 2 cycles after its triggering pixel.
- Constant 100 image, window to a SOBEL instance -> every o_grad=0. Vertical edge (0 left of x=4, 255 otherwise) -> nonzero o_grad only at o_x=3,4.
- i_start during STREAM, and i_valid in IDLE -> no state, counter or output change.
- With SOBEL_CTRL_STALL_EN, i_stall held 5 cycles mid-row -> o_ready=0 for those cycles. Pending output still appears. Total window count stays 24.
